// File: rtl/rr_req_pkg.sv
// Shared types, default parameters and counter-width helpers for the
// round-robin requester bank.
package rr_req_pkg;

  // Default configuration; N must match the width of the arbiter it drives.
  localparam int DEF_N        = 4;
  localparam int DEF_BEAT_LEN = 4;
  localparam int DEF_MAX_PEND = 7;
  localparam int DEF_TIMEOUT  = 16;

  // Per-channel protocol state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request on the line
    ST_REQ  = 2'd1,  // request raised, waiting for grant
    ST_OWN  = 2'd2,  // granted, emitting beats
    ST_GAP  = 2'd3   // forced one-cycle request drop so the arbiter rotates
  } ch_state_e;

  // Pending counter must hold 0..max_pend inclusive.
  function automatic int pend_w(input int max_pend);
    return $clog2(max_pend + 1);
  endfunction

  // Beat counter holds 0..beat_len-1; never narrower than one bit.
  function automatic int beat_w(input int beat_len);
    return (beat_len <= 1) ? 1 : $clog2(beat_len);
  endfunction

  // Wait counter saturates at timeout, so it must hold 0..timeout.
  function automatic int wait_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_req_channel.sv
// One requester channel: request FSM, pending-job counter, beat counter and,
// when RR_REQ_TIMEOUT_EN is defined, a saturating starvation wait counter.
// All outputs are decoded from flops only; no input reaches an output
// combinationally.
module rr_req_channel
  import rr_req_pkg::*;
#(
  parameter int BEAT_LEN = DEF_BEAT_LEN,
  parameter int MAX_PEND = DEF_MAX_PEND,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic job_push,
  input  logic grant,
  output logic req,
  output logic beat,
  output logic done,
  output logic pend_full,
  output logic overflow,
  output logic err_lost,
  output logic starve
);

  localparam int PW = pend_w(MAX_PEND);
  localparam int BW = beat_w(BEAT_LEN);

  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PEND);
  localparam logic [PW-1:0] PEND_ONE  = PW'(1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_LEN - 1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

  ch_state_e       state_q, state_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            err_lost_q, err_lost_d;
  logic            overflow_q, overflow_d;
  logic            complete;   // last beat of a job is being retired this cycle

  // Request protocol: next state, beat counter, grant-loss detection.
  // NOTE: every signal written here gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    err_lost_d = err_lost_q;
    complete   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q != '0) state_d = ST_REQ;
      end
      ST_REQ: begin
        // Burst starts at beat 0 whether this is a fresh job or a retry.
        if (grant) begin
          state_d    = ST_OWN;
          beat_cnt_d = '0;
        end
      end
      ST_OWN: begin
        if (beat_cnt_q == BEAT_LAST) begin
          // Last beat retires the job even if the arbiter has already let go.
          complete   = 1'b1;
          state_d    = ST_GAP;
          beat_cnt_d = '0;
        end else if (!grant) begin
          // Arbiter withdrew mid-burst: keep the job and ask again.
          err_lost_d = 1'b1;
          state_d    = ST_REQ;
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + BEAT_ONE;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pending jobs: a push and a completion in the same cycle cancel out, so a
  // full channel can accept a push on its last beat without overflowing.
  always_comb begin
    pend_d     = pend_q;
    overflow_d = 1'b0;
    if (job_push && !complete) begin
      if (pend_q == PEND_MAX) overflow_d = 1'b1;
      else                    pend_d     = pend_q + PEND_ONE;
    end else if (complete && !job_push) begin
      pend_d = pend_q - PEND_ONE;
    end
  end

  // State registers; reset discards any in-flight job and all pending work.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      pend_q     <= '0;
      err_lost_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      pend_q     <= pend_d;
      err_lost_q <= err_lost_d;
      overflow_q <= overflow_d;
    end
  end

  assign req       = (state_q == ST_REQ) || (state_q == ST_OWN);
  assign beat      = (state_q == ST_OWN);
  assign done      = (state_q == ST_OWN) && (beat_cnt_q == BEAT_LAST);
  assign pend_full = (pend_q == PEND_MAX);
  assign overflow  = overflow_q;
  assign err_lost  = err_lost_q;

`ifdef RR_REQ_TIMEOUT_EN
  localparam int WW = wait_w(TIMEOUT);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);

  logic [WW-1:0] wait_q, wait_d;
  logic          starve_q, starve_d;

  // Count unanswered request cycles, saturating at TIMEOUT; starvation sticks.
  always_comb begin
    wait_d   = wait_q;
    starve_d = starve_q;
    if (state_q == ST_REQ) begin
      if (grant)                  wait_d = '0;
      else if (wait_q != WAIT_MAX) wait_d = wait_q + WAIT_ONE;
      if (wait_d == WAIT_MAX) starve_d = 1'b1;
    end
  end

  // Wait counter and starvation flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  assign starve = starve_q;
`else
  // Without the timeout feature the flag is constant; TIMEOUT stays
  // referenced so both builds share one parameter list.
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign starve         = 1'b0;
`endif

endmodule

// File: rtl/rr_requester_bank.sv
// Requester side of a 4-way round-robin arbiter: N independent channels, each
// turning pushed jobs into fixed-length grant bursts separated by a request
// drop. Optional starvation detection is enabled by RR_REQ_TIMEOUT_EN.
module rr_requester_bank
  import rr_req_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int BEAT_LEN = DEF_BEAT_LEN,
  parameter int MAX_PEND = DEF_MAX_PEND,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] job_push,
  input  logic [N-1:0] grant,
  output logic [N-1:0] req,
  output logic [N-1:0] beat,
  output logic [N-1:0] done,
  output logic [N-1:0] pend_full,
  output logic [N-1:0] overflow,
  output logic [N-1:0] err_lost,
  output logic [N-1:0] starve
);

  // One channel per arbiter port; bit i of every vector belongs to channel i.
  for (genvar i = 0; i < N; i++) begin : g_ch
    rr_req_channel #(
      .BEAT_LEN (BEAT_LEN),
      .MAX_PEND (MAX_PEND),
      .TIMEOUT  (TIMEOUT)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .job_push  (job_push[i]),
      .grant     (grant[i]),
      .req       (req[i]),
      .beat      (beat[i]),
      .done      (done[i]),
      .pend_full (pend_full[i]),
      .overflow  (overflow[i]),
      .err_lost  (err_lost[i]),
      .starve    (starve[i])
    );
  end

endmodule

// File: doc/rr_requester_bank.md
# rr_requester_bank

Requester-side counterpart of the 4-way round-robin arbiter. Holds per-channel job counts and drives one `req` line per channel. On each `grant`, it runs a fixed-length ownership burst, then drops `req` for one cycle so the arbiter can rotate. It sits between client job sources and the arbiter's `req`/`grant` ports.

## Interface
- `N`, 4: number of channels; must match the arbiter width.
- `BEAT_LEN`, 4: cycles of ownership per granted job, range 1..255.
- `MAX_PEND`, 7: per-channel pending-job capacity, range 1..255.
- `TIMEOUT`, 16: cycles of unanswered `req` before a starvation flag (macro-dependent).

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `job_push` in N: per-channel one-cycle pulse that adds one pending job.
- `grant` in N: one-hot grant from the arbiter.
- `req` out N: request lines to the arbiter.
- `beat` out N: high on each owned cycle of a burst.
- `done` out N: one-cycle pulse on the last beat of a job.
- `pend_full` out N: pending count equals `MAX_PEND`.
- `overflow` out N: one-cycle pulse when a push is dropped.
- `err_lost` out N: sticky; `grant` withdrawn mid-burst.
- `starve` out N: sticky starvation flag; only meaningful with the macro.

## Operation
- Each channel is an independent FSM with states IDLE, REQ, OWN and GAP.
- IDLE -> REQ when pending > 0.
- REQ: `req`=1. Move to OWN when `grant[i]`=1 is sampled. The beat counter loads 0.
- OWN: `req`=1 and `beat[i]`=1 on every cycle, including the first OWN cycle. The counter increments each cycle.
  - When the counter reaches `BEAT_LEN`-1: `done[i]` pulses, pending decrements and the FSM goes to GAP.
- GAP: `req`=0 for exactly one cycle, then IDLE.
  - IDLE re-enters REQ on the next cycle if jobs remain, giving a 2-cycle minimum `req` low window.
- Grant loss: if `grant[i]`=0 in OWN before the last beat, `err_lost[i]` is set.
  - The FSM returns to REQ.
  - Pending is not decremented, and the job restarts from beat 0 on the next grant.
- Pending counter width is ceil(log2(`MAX_PEND`+1)).
  - A push at full is dropped, `overflow[i]` pulses and the count is unchanged.
  - A push in the same cycle as a completion: the count is unchanged and no overflow is flagged, even when full.
- Grants to channels in IDLE or GAP are ignored; no error is raised.
- `err_lost` and `starve` clear only on `reset`.

## Timing
- Reset values:
  - All FSMs in IDLE, all pending counts 0, all counters 0.
  - `req`, `beat`, `done`, `overflow`, `err_lost`, `starve` = 0; `pend_full` = 0.
- `job_push` at cycle t gives `req`=1 from cycle t+2 (t+1 count update, t+2 IDLE->REQ registered).
- `grant[i]` sampled at cycle g gives `beat[i]`=1 at cycle g+1 through g+`BEAT_LEN`.
  - `done[i]` is in cycle g+`BEAT_LEN`.
  - `req[i]`=0 in cycle g+`BEAT_LEN`+1.
- All outputs are registered; no combinational path from input to output.
- Asserting `reset` mid-burst clears state immediately. The in-flight job is discarded and pending jobs are lost.

## Configuration
- `RR_REQ_TIMEOUT_EN` defined:
  - A per-channel wait counter runs while the channel is in REQ and clears on entry to OWN or on reset.
  - When the counter reaches `TIMEOUT`, `starve[i]` sets (sticky).
  - The counter saturates; it does not wrap.
- Undefined: the counters are not built and `starve` is tied to 0.

## Structure
- Package `rr_req_pkg` holds:
  - the channel state enum (IDLE, REQ, OWN, GAP);
  - default constants for `N`, `BEAT_LEN`, `MAX_PEND`, `TIMEOUT`;
  - width functions for the counters.
- Sub-module `rr_req_channel` holds one channel's FSM, pending counter, beat counter and optional wait counter.
  - The top generates `N` instances and concatenates their outputs.

## Test plan
- Reset, single push on ch0, grant ch0 for 4 cycles:
  - `req[0]` rises 2 cycles after the push;
  - `beat[0]` is high for 4 cycles;
  - `done[0]` pulses once;
  - `req[0]` is low 1 cycle after `done`.
- 8 pushes on ch1 with no grant: `pend_full[1]`=1 after the 7th push; the 8th push gives `overflow[1]` for 1 cycle and the count stays 7.
- Ch2 at full (7 pending): push on its last beat gives count 7, no overflow, and `done[2]` pulses.
- Grant ch3 withdrawn after 2 beats:
  - `err_lost[3]`=1 and stays set;
  - `req[3]` stays 1;
  - the next grant gives 4 full beats.
- With `RR_REQ_TIMEOUT_EN`: ch0 requesting with no grant for 16 cycles gives `starve[0]`=1. Without the macro, `starve` stays 0.
- Reset asserted mid-burst on ch1: all outputs go to 0 asynchronously, and after release no `req` is raised without new pushes.
